// File: rtl/sha3_scan_dispatcher.sv
// Splits one nonce-range job into scanner-sized chunks and reports a single result record.
// Latency: first strobe 1 cycle after accept (if scanner idle); record 1 cycle after the final CHECK.
// Backpressure: job_ready only in IDLE; res_valid holds with stable fields until res_ready.
module sha3_scan_dispatcher #(
  parameter int PROPER = 1,
  localparam int INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24,
  parameter int NONCE_WORD = INPUT_ELEMENTS - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [INPUT_ELEMENTS*32-1:0] job_blobby,
  input  logic [63:0]                  job_threshold,
  input  logic [31:0]                  job_nonce_first,
  input  logic [31:0]                  job_nonce_last,
  input  logic                         job_abort,
  output logic                         scan_start,
  output logic [INPUT_ELEMENTS*32-1:0] scan_blobby,
  output logic [63:0]                  scan_threshold,
  input  logic                         scan_idle,
  input  logic                         scan_found,
  input  logic [31:0]                  scan_nonce,
  input  logic [31:0]                  scan_count,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_found,
  output logic [31:0]                  res_nonce,
  output logic [31:0]                  res_chunks
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [INPUT_ELEMENTS*32-1:0] blobby_q;
  logic [63:0]                  thr_q;
  logic [31:0]                  base;
  logic [31:0]                  last_q;

  logic [31:0] step;
  logic [32:0] chunk_end;
  logic        range_done;
  logic        job_empty;

  // Chunk arithmetic: 33-bit end so a range ending at 32'hFFFF_FFFF never wraps to 0.
  always_comb begin
    step       = (scan_count == 32'd0) ? 32'd1 : scan_count;
    chunk_end  = {1'b0, base} + {1'b0, step} - 33'd1;
    range_done = (chunk_end >= {1'b0, last_q});
    job_empty  = (job_nonce_last < job_nonce_first);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    job_ready  = 1'b0;
    res_valid  = 1'b0;
    scan_start = 1'b0;
    case (state)
      S_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_nxt = job_empty ? S_REPORT : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Strobe is gated by scan_idle so it can never hit a busy scanner.
        if (scan_idle) begin
          scan_start = 1'b1;
          state_nxt  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!scan_idle) begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (scan_idle) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (scan_found || range_done || job_abort) begin
          state_nxt = S_REPORT;
        end else begin
          state_nxt = S_LAUNCH;
        end
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Job latch, chunk base advance and result record fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blobby_q   <= '0;
      thr_q      <= '0;
      base       <= '0;
      last_q     <= '0;
      res_found  <= 1'b0;
      res_nonce  <= '0;
      res_chunks <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            blobby_q   <= job_blobby;
            thr_q      <= job_threshold;
            base       <= job_nonce_first;
            last_q     <= job_nonce_last;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_chunks <= '0;
          end
        end
        S_LAUNCH: begin
          if (scan_idle && (res_chunks != 32'hFFFF_FFFF)) begin
            res_chunks <= res_chunks + 32'd1;
          end
        end
        S_CHECK: begin
          if (scan_found) begin
            res_found <= 1'b1;
            res_nonce <= scan_nonce;
          end else if (!range_done && !job_abort) begin
            // range_done=0 implies base+step <= last, so this cannot overflow.
            base <= base + step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Scanner payload: latched header with the nonce word replaced by the current chunk base.
  always_comb begin
    scan_blobby                       = blobby_q;
    scan_blobby[NONCE_WORD*32 +: 32]  = base;
    scan_threshold                    = thr_q;
  end

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Directed bench for sha3_scan_dispatcher with a small behavioural scanner.
// Scanner drops idle 1 cycle after start and stays busy 4 cycles; finds are programmed per strobe index.
// Each step checks record fields, strobe counts and chunk bases against hand-computed values.
module tb_sha3_scan_dispatcher;

  localparam int N  = 20;
  localparam int NW = N - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [N*32-1:0] job_blobby = '0;
  logic [63:0]   job_threshold = '0;
  logic [31:0]   job_nonce_first = '0;
  logic [31:0]   job_nonce_last = '0;
  logic          job_abort = 1'b0;
  logic          scan_start;
  logic [N*32-1:0] scan_blobby;
  logic [63:0]   scan_threshold;
  logic          scan_idle = 1'b1;
  logic          scan_found = 1'b0;
  logic [31:0]   scan_nonce = '0;
  logic [31:0]   scan_count = 32'd32;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_found;
  logic [31:0]   res_nonce;
  logic [31:0]   res_chunks;

  int checks = 0;
  int errors = 0;

  // Behavioural scanner state.
  int          strobes = 0;
  logic [31:0] bases [0:63];
  int          busy_cnt = 0;
  logic        bad_start = 1'b0;
  logic        find_en = 1'b0;
  int          find_abs = 0;
  logic [31:0] find_nonce = '0;

  sha3_scan_dispatcher #(.PROPER(1)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_blobby(job_blobby),
    .job_threshold(job_threshold), .job_nonce_first(job_nonce_first),
    .job_nonce_last(job_nonce_last), .job_abort(job_abort),
    .scan_start(scan_start), .scan_blobby(scan_blobby), .scan_threshold(scan_threshold),
    .scan_idle(scan_idle), .scan_found(scan_found), .scan_nonce(scan_nonce),
    .scan_count(scan_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_nonce(res_nonce), .res_chunks(res_chunks)
  );

  always #5 clk = ~clk;

  // Scanner model: records each chunk base, goes busy, returns idle with programmed result.
  always @(posedge clk) begin
    if (scan_start) begin
      if (!scan_idle) bad_start <= 1'b1;
      bases[strobes[5:0]] <= scan_blobby[NW*32 +: 32];
      strobes   <= strobes + 1;
      scan_idle <= 1'b0;
      busy_cnt  <= 3;
      scan_found <= find_en && (strobes == find_abs);
      scan_nonce <= (find_en && (strobes == find_abs)) ? find_nonce : 32'h0;
    end else if (!scan_idle) begin
      if (busy_cnt == 0) scan_idle <= 1'b1;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer_job(input logic [31:0] first, input logic [31:0] last);
    @(negedge clk);
    for (int i = 0; i < N; i++) job_blobby[i*32 +: 32] = 32'hA500_0000 + i;
    job_threshold   = 64'h0000_FFFF_1234_5678;
    job_nonce_first = first;
    job_nonce_last  = last;
    job_valid       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("res_timeout", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("job_ready_after_take", {63'd0, job_ready}, 64'd1);
    chk("res_valid_after_take", {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    int s0;
    int n;
    // Reset and idle checks.
    repeat (3) @(negedge clk);
    chk("rst_job_ready_during", {63'd0, job_ready}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_chunks", {32'd0, res_chunks}, 64'd0);
    chk("rst_scan_blobby_nonce", {32'd0, scan_blobby[NW*32 +: 32]}, 64'd0);
    chk("rst_scan_threshold", scan_threshold, 64'd0);
    chk("rst_scan_start", {63'd0, scan_start}, 64'd0);

    // 1: 0..99, count 32, no find -> bases 0,32,64,96, 4 chunks.
    s0 = strobes;
    offer_job(32'd0, 32'd99);
    wait_res();
    chk("t1_strobes", 64'(strobes - s0), 64'd4);
    for (int k = 0; k < 4; k++) chk("t1_base", {32'd0, bases[s0 + k]}, 64'(32 * k));
    chk("t1_found", {63'd0, res_found}, 64'd0);
    chk("t1_nonce", {32'd0, res_nonce}, 64'd0);
    chk("t1_chunks", {32'd0, res_chunks}, 64'd4);
    chk("t1_job_ready", {63'd0, job_ready}, 64'd0);
    chk("t1_threshold", scan_threshold, 64'h0000_FFFF_1234_5678);
    chk("t1_hdr_word0", {32'd0, scan_blobby[31:0]}, 64'hA500_0000);
    take_res();

    // 2: same range, nonce 70 found in chunk 3.
    s0 = strobes;
    find_en = 1'b1; find_abs = s0 + 2; find_nonce = 32'd70;
    offer_job(32'd0, 32'd99);
    wait_res();
    chk("t2_strobes", 64'(strobes - s0), 64'd3);
    chk("t2_found", {63'd0, res_found}, 64'd1);
    chk("t2_nonce", {32'd0, res_nonce}, 64'd70);
    chk("t2_chunks", {32'd0, res_chunks}, 64'd3);
    find_en = 1'b0;
    take_res();

    // 3: top of range, no wrap.
    s0 = strobes;
    offer_job(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wait_res();
    chk("t3_strobes", 64'(strobes - s0), 64'd1);
    chk("t3_base", {32'd0, bases[s0]}, 64'hFFFF_FFF0);
    chk("t3_chunks", {32'd0, res_chunks}, 64'd1);
    chk("t3_found", {63'd0, res_found}, 64'd0);
    take_res();

    // 4: empty range -> record 1 cycle after accept, no strobe.
    s0 = strobes;
    offer_job(32'd10, 32'd5);
    chk("t4_res_valid_1cyc", {63'd0, res_valid}, 64'd1);
    chk("t4_found", {63'd0, res_found}, 64'd0);
    chk("t4_chunks", {32'd0, res_chunks}, 64'd0);
    chk("t4_strobes", 64'(strobes - s0), 64'd0);
    take_res();

    // 5: abort during chunk 2 of 4 (0..127).
    s0 = strobes;
    offer_job(32'd0, 32'd127);
    n = 0;
    while (strobes - s0 < 2 && n < 200) begin @(negedge clk); n++; end
    chk("t5_reach_chunk2", 64'(strobes - s0), 64'd2);
    job_abort = 1'b1;
    wait_res();
    chk("t5_strobes", 64'(strobes - s0), 64'd2);
    chk("t5_found", {63'd0, res_found}, 64'd0);
    chk("t5_chunks", {32'd0, res_chunks}, 64'd2);
    job_abort = 1'b0;
    take_res();

    // 5b: scan_count 0 steps by 1 -> 3..4 gives 2 chunks at 3 and 4.
    scan_count = 32'd0;
    s0 = strobes;
    offer_job(32'd3, 32'd4);
    wait_res();
    chk("t5b_strobes", 64'(strobes - s0), 64'd2);
    chk("t5b_base1", {32'd0, bases[s0 + 1]}, 64'd4);
    chk("t5b_chunks", {32'd0, res_chunks}, 64'd2);
    take_res();
    scan_count = 32'd32;

    // 6: reset during WAIT_IDLE.
    s0 = strobes;
    offer_job(32'd0, 32'd999);
    n = 0;
    while (strobes - s0 < 1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t6_scanner_busy", {63'd0, scan_idle}, 64'd0);
    chk("t6_chunks_pre", {32'd0, res_chunks}, 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_chunks", {32'd0, res_chunks}, 64'd0);
    chk("t6_rst_start", {63'd0, scan_start}, 64'd0);
    chk("t6_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("t6_rst_blobby_nonce", {32'd0, scan_blobby[NW*32 +: 32]}, 64'd0);
    chk("t6_rst_hdr_word0", {32'd0, scan_blobby[31:0]}, 64'd0);
    chk("t6_rst_threshold", scan_threshold, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_job_ready", {63'd0, job_ready}, 64'd1);
    s0 = strobes;
    offer_job(32'd5, 32'd20);
    wait_res();
    chk("t6_strobes", 64'(strobes - s0), 64'd1);
    chk("t6_base", {32'd0, bases[s0]}, 64'd5);
    chk("t6_chunks", {32'd0, res_chunks}, 64'd1);
    take_res();

    // 7: res_ready held low 10 cycles, found nonce 7 in chunk 1.
    s0 = strobes;
    find_en = 1'b1; find_abs = s0; find_nonce = 32'd7;
    offer_job(32'd0, 32'd99);
    wait_res();
    for (int c = 0; c < 10; c++) begin
      chk("t7_res_valid", {63'd0, res_valid}, 64'd1);
      chk("t7_found", {63'd0, res_found}, 64'd1);
      chk("t7_nonce", {32'd0, res_nonce}, 64'd7);
      chk("t7_chunks", {32'd0, res_chunks}, 64'd1);
      chk("t7_job_ready", {63'd0, job_ready}, 64'd0);
      @(negedge clk);
    end
    find_en = 1'b0;
    take_res();

    chk("no_start_while_busy", {63'd0, bad_start}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
